// File: rtl/bus_transfer_scheduler.sv
// Bus transfer scheduler: round-robin arbiter and strobe sequencer for
// register-to-register moves on a shared tri-state data bus. Each move is
// DRIVE (source on bus, settle) -> LATCH (destination loads) -> ACK.
// Requests whose source or destination index does not exist go straight
// to ACK with err set and never touch the bus.
module bus_transfer_scheduler #(
   parameter int NREQ = 4,
   parameter int NREG = 8,
   parameter int SELW = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*SELW-1:0] req_src,
   input  logic [NREQ*SELW-1:0] req_dst,
   output logic [NREQ-1:0]      ack,
   output logic                 err,
   output logic [NREG-1:0]      reg_out_en,
   output logic [NREG-1:0]      reg_in_en,
   output logic                 busy
);

   localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, DRIVE, LATCH, ACK} state_t;

   // captured transfer: who was granted and which registers it moves between
   typedef struct packed {
      logic [PTRW-1:0] gnt;
      logic [SELW-1:0] src;
      logic [SELW-1:0] dst;
   } xfer_t;

   logic [NREQ-1:0][SELW-1:0] src_a;
   logic [NREQ-1:0][SELW-1:0] dst_a;

   state_t          state;
   logic [PTRW-1:0] ptr;
   xfer_t           cur;

   logic            found;
   xfer_t           win;
   logic            win_bad;

   assign src_a = req_src;
   assign dst_a = req_dst;

   // k-th requester in the search order that starts at the pointer
   function automatic logic [PTRW-1:0] rr_idx(input logic [PTRW-1:0] p, input int k);
      int s;
      s = int'(p) + k;
      if (s >= NREQ) s = s - NREQ;
      return PTRW'(s);
   endfunction

   // one-hot register strobe; an index with no register decodes to zero
   function automatic logic [NREG-1:0] dec_reg(input logic [SELW-1:0] i);
      logic [NREG-1:0] d;
      for (int k = 0; k < NREG; k++) d[k] = (int'(i) == k);
      return d;
   endfunction

   // one-hot requester acknowledge
   function automatic logic [NREQ-1:0] dec_req(input logic [PTRW-1:0] g);
      logic [NREQ-1:0] d;
      for (int k = 0; k < NREQ; k++) d[k] = (int'(g) == k);
      return d;
   endfunction

   // round-robin pick: first requesting slot at or above the pointer, wrapping
   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!found && req[rr_idx(ptr, k)]) begin
            found   = 1'b1;
            win.gnt = rr_idx(ptr, k);
         end
      end
      win.src = src_a[win.gnt];
      win.dst = dst_a[win.gnt];
      win_bad = found && ((int'(win.src) >= NREG) || (int'(win.dst) >= NREG));
   end

   // sequencer; outputs are registered alongside the state they belong to
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         ptr        <= '0;
         cur        <= '0;
         ack        <= '0;
         err        <= 1'b0;
         reg_out_en <= '0;
         reg_in_en  <= '0;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               ack        <= '0;
               err        <= 1'b0;
               reg_out_en <= '0;
               reg_in_en  <= '0;
               if (found) begin
                  cur  <= win;
                  busy <= 1'b1;
                  if (win_bad) begin
                     // nothing valid to move: complete immediately with err
                     state <= ACK;
                     ack   <= dec_req(win.gnt);
                     err   <= 1'b1;
                  end else begin
                     state      <= DRIVE;
                     reg_out_en <= dec_reg(win.src);
                  end
               end
            end
            DRIVE: begin
               // source keeps driving; destination loads only after the settle cycle
               state      <= LATCH;
               reg_out_en <= dec_reg(cur.src);
               reg_in_en  <= dec_reg(cur.dst);
            end
            LATCH: begin
               state      <= ACK;
               reg_out_en <= '0;
               reg_in_en  <= '0;
               ack        <= dec_req(cur.gnt);
               err        <= 1'b0;
            end
            ACK: begin
               state <= IDLE;
               ack   <= '0;
               err   <= 1'b0;
               busy  <= 1'b0;
               ptr   <= (cur.gnt == PTRW'(NREQ - 1)) ? '0 : cur.gnt + 1'b1;
            end
            default: begin
               state      <= IDLE;
               ack        <= '0;
               err        <= 1'b0;
               reg_out_en <= '0;
               reg_in_en  <= '0;
               busy       <= 1'b0;
            end
         endcase
      end
   end

   // bus-safety invariants
   a_out_onehot : assert property (@(posedge clk) disable iff (!rst) $countones(reg_out_en) <= 1);
   a_in_onehot  : assert property (@(posedge clk) disable iff (!rst) $countones(reg_in_en) <= 1);
   a_in_w_out   : assert property (@(posedge clk) disable iff (!rst) (reg_in_en != '0) |-> (reg_out_en != '0));
   a_ack_onehot : assert property (@(posedge clk) disable iff (!rst) $countones(ack) <= 1);

endmodule

// File: doc/bus_transfer_scheduler.md
Name: bus_transfer_scheduler

Overview:
- Arbitrates register-to-register moves on the shared tri-state data bus between several requesters (instruction sequencer, debug port, I/O unit).
- Drives the per-register output-enable (register_out) and load-enable (register_in) strobes.
- Guarantees at most one bus driver per cycle and a settle cycle before any load.
- Sits between the control unit and the bank of bus registers.

Parameters:
NREQ, 4, number of requesters (>=2)
NREG, 8, number of registers attached to the bus (<= 2**SELW)
SELW, 3, width of a register index

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
req  input  NREQ  per-requester transfer request, level
req_src  input  NREQ*SELW  source index; requester i uses bits [i*SELW +: SELW]
req_dst  input  NREQ*SELW  destination index, same packing
ack  output  NREQ  one-cycle completion pulse to the granted requester
err  output  1  high with ack when the completed request had an invalid index
reg_out_en  output  NREG  one-hot/zero bus-drive enables, to register_out
reg_in_en  output  NREG  one-hot/zero load enables, to register_in
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, rr pointer=0; ack, err, reg_out_en, reg_in_en and busy are all 0 immediately. No ack is ever issued for an in-flight transfer aborted by reset.
- All outputs are registered, decoded from state plus captured grant/src/dst.
- States: IDLE, DRIVE, LATCH, ACK.
- IDLE: if any req bit is high, pick the winner round-robin, starting the search at pointer and scanning upward mod NREQ.
  - On the same edge, capture grant, src and dst.
  - If src or dst >= NREG: go to ACK with err flag set and no strobes.
  - Otherwise go to DRIVE.
  - If no req: stay in IDLE.
- DRIVE: reg_out_en[src]=1; all other enables 0 (bus settle cycle). Next state: LATCH.
- LATCH: reg_out_en[src]=1 and reg_in_en[dst]=1. Destination captures on the edge ending LATCH. Next state: ACK.
- ACK: all enables 0; ack[grant]=1; err=captured err flag. Pointer <= (grant+1) mod NREQ. Next state: IDLE.
- Latency: req sampled at edge E0 -> DRIVE after E0 -> LATCH after E1 -> dst loaded at E2 -> ack cycle after E2 -> IDLE after E3. Throughput is 1 transfer per 4 cycles under continuous requests.
- Handshake:
  - Requester holds req, src and dst stable until it sees ack.
  - Indices are captured at grant; later changes have no effect on the current transfer.
  - A req still high in the IDLE cycle after ACK is treated as a new request. It is eligible, but lower priority than others because the pointer has advanced.
  - A req dropped before grant is simply never granted; no ack is issued.
- src == dst is legal: it performs the normal DRIVE/LATCH sequence (register reloads its own value) and acks without err.
- Invariants, every cycle:
  - popcount(reg_out_en) <= 1.
  - popcount(reg_in_en) <= 1.
  - reg_in_en is nonzero only while reg_out_en is nonzero.
  - popcount(ack) <= 1.
- Simultaneous requests: exactly one is granted per arbitration. Starvation-free: any held request is granted within NREQ arbitrations.
- Reset released mid-sequence: resumes in IDLE with pointer 0.

Test Plan:
- Single move: req[0]=1, src=2, dst=5 -> reg_out_en=8'b0000_0100 for 2 cycles; reg_in_en=8'b0010_0000 in 2nd cycle only; ack=4'b0001 one cycle later; err=0; busy high for exactly 3 cycles.
- Round-robin: req=4'b1111 held continuously from reset -> acks in order 0,1,2,3,0; successive acks 4 cycles apart.
- Invalid index: NREG=6, req[1]=1, dst=7 -> no enable ever asserted; ack=4'b0010 with err=1 on the cycle after grant.
- Self-move and index change: src=dst=3 -> both enables on bit 3 during LATCH, normal ack. Changing req_src after grant does not alter reg_out_en.
- Reset mid-transfer: drive rst=0 during LATCH -> all outputs 0 within the same cycle (asynchronous), no ack. After rst=1, a pending req[2] is granted with a fresh 4-cycle sequence.
- Random soak: 10k cycles of random req, src and dst. Checker asserts the one-hot invariants, ack only to requesters with req high, and a scoreboard model of an 8x16 register file matching transfer results.
